// File: rtl/noc_vc_input_buffer_pkg.sv
// ============================================================================
// Module   : noc_vc_input_buffer_pkg
// Brief    : Shared defaults, read-FSM encoding and helpers for the VC buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package noc_vc_input_buffer_pkg;

    localparam int c_tam_flit_default = 16;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        SIZE = 2'd1,
        PAY  = 2'd2
    } vc_state_e;

    // A single VC still needs a 1-bit id port.
    function automatic int vc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_vc_fifo.sv
// ============================================================================
// Module   : noc_vc_fifo
// Brief    : Single-VC circular FIFO with packet-tracking read FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module noc_vc_fifo
    import noc_vc_input_buffer_pkg::*;
#(
    parameter int TAM_FLIT  = c_tam_flit_default,
    parameter int BUF_DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_push,
    input  logic [TAM_FLIT-1:0] i_data,
    input  logic                i_pop,
    output logic                o_credit,
    output logic                o_valid,
    output logic [TAM_FLIT-1:0] o_data,
    output logic                o_head,
    output logic                o_eop
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    logic [TAM_FLIT-1:0] r_mem_q [BUF_DEPTH];
    logic [PW-1:0]       r_wr_ptr_q, w_wr_ptr_d;
    logic [PW-1:0]       r_rd_ptr_q, w_rd_ptr_d;
    logic [CW-1:0]       r_count_q,  w_count_d;
    logic [TAM_FLIT-1:0] r_rem_q,    w_rem_d;
    vc_state_e           r_state_q,  w_state_d;

    logic                w_push_ok;
    logic                w_pop_ok;
    logic [TAM_FLIT-1:0] w_head_flit;

    assign o_credit    = (r_count_q < CW'(BUF_DEPTH));
    assign o_valid     = (r_count_q != '0);
    assign w_push_ok   = i_push && o_credit;
    assign w_pop_ok    = i_pop && o_valid;
    assign w_head_flit = r_mem_q[r_rd_ptr_q];
    assign o_data      = w_head_flit;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        w_state_d  = r_state_q;
        w_rem_d    = r_rem_q;
        if (w_push_ok) begin
            w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        end
        if (w_pop_ok) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
        if (w_pop_ok) begin
            case (r_state_q)
                HDR:  w_state_d = SIZE;
                SIZE: begin
                    if (w_head_flit == '0) begin
                        w_state_d = HDR;
                    end else begin
                        w_rem_d   = w_head_flit;
                        w_state_d = PAY;
                    end
                end
                PAY: begin
                    w_rem_d = r_rem_q - 1'b1;
                    if (r_rem_q == TAM_FLIT'(1)) begin
                        w_state_d = HDR;
                    end
                end
                default: w_state_d = HDR;
            endcase
        end
    end

    // Flags are gated by o_valid so an empty VC never advertises a boundary.
    always_comb begin
        o_head = o_valid && (r_state_q == HDR);
        o_eop  = o_valid && (((r_state_q == SIZE) && (w_head_flit == '0)) ||
                             ((r_state_q == PAY)  && (r_rem_q == TAM_FLIT'(1))));
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            r_rem_q    <= '0;
            r_state_q  <= HDR;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_rem_q    <= w_rem_d;
            r_state_q  <= w_state_d;
        end
    end

    // Storage needs no reset: an empty count hides stale entries.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem_q[r_wr_ptr_q] <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_vc_input_buffer.sv
// ============================================================================
// Module   : noc_vc_input_buffer
// Brief    : Credit-based multi-VC router input buffer with overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module noc_vc_input_buffer
    import noc_vc_input_buffer_pkg::*;
#(
    parameter int TAM_FLIT  = c_tam_flit_default,
    parameter int NUM_VC    = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_rx,
    input  logic [vc_width(NUM_VC)-1:0]  i_vc,
    input  logic [TAM_FLIT-1:0]          i_data,
    output logic [NUM_VC-1:0]            o_credit,
    output logic [NUM_VC-1:0]            o_valid,
    output logic [NUM_VC*TAM_FLIT-1:0]   o_data,
    output logic [NUM_VC-1:0]            o_head,
    output logic [NUM_VC-1:0]            o_eop,
    input  logic [NUM_VC-1:0]            i_pop,
    output logic                         o_ovf
);

    logic [NUM_VC-1:0] w_push;
    logic              w_drop;
    logic              r_ovf_q, w_ovf_d;

    generate
        for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
            assign w_push[v] = i_rx && (int'(i_vc) == v);

            noc_vc_fifo #(
                .TAM_FLIT  (TAM_FLIT),
                .BUF_DEPTH (BUF_DEPTH)
            ) u_fifo (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_push   (w_push[v]),
                .i_data   (i_data),
                .i_pop    (i_pop[v]),
                .o_credit (o_credit[v]),
                .o_valid  (o_valid[v]),
                .o_data   (o_data[v*TAM_FLIT +: TAM_FLIT]),
                .o_head   (o_head[v]),
                .o_eop    (o_eop[v])
            );
        end
    endgenerate

    // Out-of-range VC ids decode to no push at all, so they count as drops.
    always_comb begin
        w_drop  = i_rx && ((w_push & o_credit) == '0);
        w_ovf_d = r_ovf_q || w_drop;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ovf_q <= 1'b0;
        end else begin
            r_ovf_q <= w_ovf_d;
        end
    end

    assign o_ovf = r_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_noc_vc_input_buffer.sv
// ============================================================================
// Module   : tb_noc_vc_input_buffer
// Brief    : Vector table, directed corner sequences and random traffic vs model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_noc_vc_input_buffer;

    localparam int TF    = 16;
    localparam int NV    = 2;
    localparam int DEPTH = 4;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b0;
    logic           i_rx  = 1'b0;
    logic [0:0]     i_vc  = '0;
    logic [TF-1:0]  i_data = '0;
    logic [NV-1:0]  o_credit, o_valid, o_head, o_eop;
    logic [NV*TF-1:0] o_data;
    logic [NV-1:0]  i_pop = '0;
    logic           o_ovf;

    int errors = 0;
    int checks = 0;

    noc_vc_input_buffer #(.TAM_FLIT(TF), .NUM_VC(NV), .BUF_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx(i_rx), .i_vc(i_vc), .i_data(i_data),
        .o_credit(o_credit), .o_valid(o_valid), .o_data(o_data), .o_head(o_head),
        .o_eop(o_eop), .i_pop(i_pop), .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    // Reference: per-VC flit queue plus position of the head flit within its packet.
    logic [TF-1:0] mq [NV][$];
    int            pos [NV];
    int            plen [NV];
    bit            m_ovf;

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            mq[v].delete();
            pos[v]  = 0;
            plen[v] = 0;
        end
        m_ovf = 0;
    endtask

    task automatic model_edge(input logic rx, input int vc, input logic [TF-1:0] d,
                              input logic [NV-1:0] pop);
        bit pop_ok [NV];
        bit push_ok [NV];
        bit accepted;
        logic [TF-1:0] f;
        accepted = 0;
        for (int v = 0; v < NV; v++) begin
            pop_ok[v]  = pop[v] && (mq[v].size() > 0);
            push_ok[v] = rx && (vc == v) && (mq[v].size() < DEPTH);
        end
        for (int v = 0; v < NV; v++) begin
            if (pop_ok[v]) begin
                f = mq[v].pop_front();
                if (pos[v] == 0) pos[v] = 1;
                else if (pos[v] == 1) begin
                    if (f == 0) pos[v] = 0;
                    else begin plen[v] = int'(f); pos[v] = 2; end
                end else if (pos[v] == plen[v] + 1) pos[v] = 0;
                else pos[v] = pos[v] + 1;
            end
            if (push_ok[v]) begin
                mq[v].push_back(d);
                accepted = 1;
            end
        end
        if (rx && !accepted) m_ovf = 1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [NV-1:0] e_cr, e_va, e_hd, e_eo;
        for (int v = 0; v < NV; v++) begin
            e_cr[v] = mq[v].size() < DEPTH;
            e_va[v] = mq[v].size() > 0;
            e_hd[v] = e_va[v] && (pos[v] == 0);
            e_eo[v] = e_va[v] && (((pos[v] == 1) && (mq[v][0] == 0)) ||
                                  ((pos[v] >= 2) && (pos[v] == plen[v] + 1)));
        end
        chk("credit", 64'(o_credit), 64'(e_cr));
        chk("valid",  64'(o_valid),  64'(e_va));
        chk("head",   64'(o_head),   64'(e_hd));
        chk("eop",    64'(o_eop),    64'(e_eo));
        chk("ovf",    64'(o_ovf),    64'(m_ovf));
        for (int v = 0; v < NV; v++) begin
            if (e_va[v]) chk($sformatf("data_vc%0d", v), 64'(o_data[v*TF +: TF]), 64'(mq[v][0]));
        end
    endtask

    // One clock: drive at edge+1, apply edge, advance model, check outputs.
    task automatic cycle(input logic rx, input int vc, input logic [TF-1:0] d,
                         input logic [NV-1:0] pop);
        i_rx = rx; i_vc = vc[0]; i_data = d; i_pop = pop;
        @(posedge i_clk);
        model_edge(rx, vc, d, pop);
        #1;
        i_rx = 1'b0; i_pop = '0;
        check_model();
    endtask

    task automatic sync_reset();
        i_rst = 1'b0;
        #2;
        model_reset();
        i_rst = 1'b1;
        #1;
        check_model();
    endtask

    typedef struct {
        logic          rx;
        int            vc;
        logic [TF-1:0] data;
        logic [NV-1:0] pop;
        logic [NV-1:0] e_valid, e_credit, e_head, e_eop;
        logic [TF-1:0] e_d0;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1'b1, 0, 16'h0011, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 16'h0011};
        tbl[1]  = '{1'b1, 0, 16'h0002, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 16'h0011};
        tbl[2]  = '{1'b1, 0, 16'hAAAA, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 16'h0011};
        tbl[3]  = '{1'b1, 0, 16'hBBBB, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 16'h0011};
        tbl[4]  = '{1'b0, 0, 16'h0000, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 16'h0002};
        tbl[5]  = '{1'b0, 0, 16'h0000, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 16'hAAAA};
        tbl[6]  = '{1'b0, 0, 16'h0000, 2'b01, 2'b01, 2'b11, 2'b00, 2'b01, 16'hBBBB};
        tbl[7]  = '{1'b0, 0, 16'h0000, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 16'h0000};
        tbl[8]  = '{1'b1, 0, 16'h0044, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 16'h0044};
        tbl[9]  = '{1'b1, 0, 16'h0000, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 16'h0044};
        tbl[10] = '{1'b1, 0, 16'h0055, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 16'h0044};
        tbl[11] = '{1'b0, 0, 16'h0000, 2'b01, 2'b01, 2'b11, 2'b00, 2'b01, 16'h0000};
        tbl[12] = '{1'b0, 0, 16'h0000, 2'b01, 2'b01, 2'b11, 2'b01, 2'b00, 16'h0055};
        tbl[13] = '{1'b0, 0, 16'h0000, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 16'h0000};

        model_reset();
        #12;
        chk("rst_credit", 64'(o_credit), 64'h3);
        chk("rst_valid",  64'(o_valid),  64'h0);
        chk("rst_ovf",    64'(o_ovf),    64'h0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].rx, tbl[i].vc, tbl[i].data, tbl[i].pop);
            chk($sformatf("tbl%0d_valid", i),  64'(o_valid),  64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_credit", i), 64'(o_credit), 64'(tbl[i].e_credit));
            chk($sformatf("tbl%0d_head", i),   64'(o_head),   64'(tbl[i].e_head));
            chk($sformatf("tbl%0d_eop", i),    64'(o_eop),    64'(tbl[i].e_eop));
            if (tbl[i].e_valid[0]) chk($sformatf("tbl%0d_d0", i), 64'(o_data[TF-1:0]), 64'(tbl[i].e_d0));
        end

        // VC1 fills up; the fifth flit must be dropped without touching VC1 or VC0.
        cycle(1'b1, 1, 16'h1111, 2'b00);
        cycle(1'b1, 1, 16'h0003, 2'b00);
        cycle(1'b1, 1, 16'h2222, 2'b00);
        cycle(1'b1, 1, 16'h3333, 2'b00);
        chk("vc1_full_credit", 64'(o_credit), 64'h1);
        chk("vc1_full_noovf",  64'(o_ovf),    64'h0);
        cycle(1'b1, 1, 16'h9999, 2'b00);
        chk("vc1_drop_ovf",   64'(o_ovf), 64'h1);
        chk("vc1_drop_head",  64'(o_data[TF +: TF]), 64'h1111);
        chk("vc1_drop_vc0cr", 64'(o_credit[0]), 64'h1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, '0, 2'b10);
        chk("vc1_drained", 64'(o_valid), 64'h0);

        // Reset asserted mid-packet between clock edges.
        cycle(1'b1, 0, 16'h0077, 2'b00);
        cycle(1'b1, 0, 16'h0005, 2'b00);
        i_rst = 1'b0;
        #2;
        chk("arst_credit", 64'(o_credit), 64'h3);
        chk("arst_valid",  64'(o_valid),  64'h0);
        chk("arst_ovf",    64'(o_ovf),    64'h0);
        chk("arst_head",   64'(o_head),   64'h0);
        model_reset();
        i_rst = 1'b1;

        // Full VC0 with a push and pop in the same cycle: push is refused.
        cycle(1'b1, 0, 16'h0100, 2'b00);
        cycle(1'b1, 0, 16'h0001, 2'b00);
        cycle(1'b1, 0, 16'h0200, 2'b00);
        cycle(1'b1, 0, 16'h0300, 2'b00);
        cycle(1'b1, 0, 16'hDEAD, 2'b01);
        chk("pp_full_ovf",    64'(o_ovf),       64'h1);
        chk("pp_full_credit", 64'(o_credit[0]), 64'h1);
        chk("pp_full_head",   64'(o_data[TF-1:0]), 64'h0001);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, '0, 2'b01);
        chk("pp_drained", 64'(o_valid[0]), 64'h0);

        // Interleaved streams with pointer wrap on both VCs.
        sync_reset();
        begin
            logic [TF-1:0] s0 [6];
            logic [TF-1:0] s1 [6];
            s0 = '{16'h00A0, 16'h0004, 16'hA001, 16'hA002, 16'hA003, 16'hA004};
            s1 = '{16'h00B0, 16'h0001, 16'hB001, 16'h00B1, 16'h0000, 16'h00B2};
            for (int i = 0; i < 12; i++) begin
                if (i % 2 == 0) cycle(1'b1, 0, s0[i/2], (i % 4 == 2) ? 2'b11 : 2'b00);
                else            cycle(1'b1, 1, s1[i/2], (i % 4 == 3) ? 2'b11 : 2'b00);
            end
            for (int i = 0; i < 8; i++) cycle(1'b0, 0, '0, 2'b11);
            chk("ilv_drained", 64'(o_valid), 64'h0);
        end

        // Random traffic, small size flits so packets actually complete.
        sync_reset();
        for (int i = 0; i < 600; i++) begin
            logic [TF-1:0] d;
            d = ($urandom_range(0, 3) == 0) ? TF'($urandom) : TF'($urandom_range(0, 3));
            cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, NV - 1)), d,
                  NV'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
